// File: rtl/ts_packet_mux_if.sv
// Source/sink bundle of the TS mux: per-source ready/enable/data in, read pulses and the muxed byte stream out.
// master = packet buffers plus downstream sink, slave = the mux.
interface ts_packet_mux_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0]   GOT_FULL_PACKET;
    logic [N_SRC-1:0]   SRC_ENABLE;
    logic [8*N_SRC-1:0] DATA_IN_BUS;
    logic [N_SRC-1:0]   GIVE_ME_ONE_PACKET;
    logic [7:0]         DATA_OUT;
    logic               D_VALID_OUT;
    logic               P_SYNC_OUT;

    modport master (
        output GOT_FULL_PACKET, SRC_ENABLE, DATA_IN_BUS,
        input  GIVE_ME_ONE_PACKET, DATA_OUT, D_VALID_OUT, P_SYNC_OUT
    );

    modport slave (
        input  GOT_FULL_PACKET, SRC_ENABLE, DATA_IN_BUS,
        output GIVE_ME_ONE_PACKET, DATA_OUT, D_VALID_OUT, P_SYNC_OUT
    );
endinterface

// File: rtl/ts_packet_mux.sv
// Round-robin TS mux with 4-byte pseudo-header and null stuffing; header byte0 one cycle after the grant.
// No backpressure: the sink takes a byte every cycle, sources are only gated by GOT_FULL_PACKET/SRC_ENABLE.
module ts_packet_mux #(
    parameter int N_SRC       = 4,
    parameter int PKT_LEN     = 188,
    parameter int RD_LAT      = 2,
    parameter int NULL_INSERT = 1,
    parameter int NULL_GAP    = 16
) (
    input  logic           SYS_CLK,
    input  logic           RST,
    output logic           DCLK_OUT,
    ts_packet_mux_if.slave bus
);
    localparam int PKT_BYTES = PKT_LEN + 4;
    localparam int CNT_W     = $clog2(PKT_BYTES);
    localparam int SRC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int IDLE_W    = $clog2(NULL_GAP + 1);
    localparam int GIVE_AT   = 3 - RD_LAT;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PKT_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(NULL_GAP - 1);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_HEADER,
        ST_PAYLOAD
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SRC_W-1:0]  sel_q, sel_d;
    logic [SRC_W-1:0]  rr_q, rr_d;
    logic              null_q, null_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [7:0]        cont_q [N_SRC];
    logic [7:0]        cont_d [N_SRC];
    logic [7:0]        dat_q, dat_d;
    logic              vld_q, vld_d;
    logic              psync_q, psync_d;
    logic [N_SRC-1:0]  give_q, give_d;
    logic              live_q, live_d;

    logic [N_SRC-1:0]  ready;
    logic              hi_vld, lo_vld, grant_vld;
    logic [SRC_W-1:0]  hi_idx, lo_idx, grant_idx, rr_nxt;
    logic [7:0]        src_bytes [N_SRC];
    logic [7:0]        sel_byte;
    logic [7:0]        null_fill;
    logic              finish;
    logic [N_SRC-1:0]  give_early;

    assign ready = bus.GOT_FULL_PACKET & bus.SRC_ENABLE;

    // Two-pass priority: lowest ready index at/after the pointer, else lowest below it.
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int s = N_SRC - 1; s >= 0; s--) begin
            if (ready[s]) begin
                if (SRC_W'(s) >= rr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = SRC_W'(s);
                end else begin
                    lo_vld = 1'b1;
                    lo_idx = SRC_W'(s);
                end
            end
        end
    end

    // With RD_LAT=4 the read pulse is combinational in the grant cycle, so the first cycle
    // after reset is kept grant-free to keep that pulse clean of reset.
    assign grant_vld = (hi_vld || lo_vld) && ((RD_LAT < 4) || live_q);
    assign grant_idx = hi_vld ? hi_idx : lo_idx;
    assign rr_nxt    = (grant_idx == SRC_W'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        for (int s = 0; s < N_SRC; s++) begin
            src_bytes[s] = bus.DATA_IN_BUS[8*s +: 8];
        end
    end

    assign sel_byte = src_bytes[sel_q];
    assign finish   = (state_q == ST_PAYLOAD) && (cnt_q == LAST_CNT) && !null_q;

    always_comb begin
        case (cnt_q)
            CNT_W'(4): null_fill = 8'h1F;
            CNT_W'(6): null_fill = 8'h10;
            default:   null_fill = 8'hFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        null_d  = null_q;
        idle_d  = idle_q;
        dat_d   = 8'h00;
        vld_d   = 1'b0;
        psync_d = 1'b0;
        give_d  = '0;
        live_d  = 1'b1;

        case (state_q)
            ST_ARB: begin
                if (grant_vld) begin
                    state_d = ST_HEADER;
                    cnt_d   = '0;
                    sel_d   = grant_idx;
                    null_d  = 1'b0;
                    rr_d    = rr_nxt;
                    idle_d  = '0;
                    dat_d   = {{(8-SRC_W){1'b0}}, grant_idx};
                    vld_d   = 1'b1;
                end else if (NULL_INSERT != 0) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = ST_HEADER;
                        cnt_d   = '0;
                        null_d  = 1'b1;
                        idle_d  = '0;
                        dat_d   = 8'hFF;
                        vld_d   = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                vld_d = 1'b1;
                cnt_d = cnt_q + 1'b1;
                case (cnt_q[1:0])
                    2'd0: dat_d = null_q ? 8'hFF : {{(8-SRC_W){1'b0}}, sel_q} + 8'd2;
                    2'd1: dat_d = null_q ? 8'h00 : cont_q[sel_q];
                    2'd2: dat_d = 8'h00;
                    default: begin
                        dat_d   = null_q ? 8'h47 : sel_byte;
                        psync_d = 1'b1;
                        state_d = ST_PAYLOAD;
                    end
                endcase
            end
            ST_PAYLOAD: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end else begin
                    vld_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    dat_d = null_q ? null_fill : sel_byte;
                end
            end
            default: begin
                state_d = ST_ARB;
                cnt_d   = '0;
            end
        endcase

        // Registered read pulse lands in packet cycle GIVE_AT; negative GIVE_AT never matches.
        for (int s = 0; s < N_SRC; s++) begin
            give_d[s] = vld_d && !null_d && (int'(cnt_d) == GIVE_AT) && (sel_d == SRC_W'(s));
        end

        for (int s = 0; s < N_SRC; s++) begin
            cont_d[s] = cont_q[s] + ((finish && (sel_q == SRC_W'(s))) ? 8'd1 : 8'd0);
        end
    end

    always_comb begin
        for (int s = 0; s < N_SRC; s++) begin
            give_early[s] = (RD_LAT >= 4) && (state_q == ST_ARB) && grant_vld
                            && (grant_idx == SRC_W'(s));
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_ARB;
            cnt_q   <= '0;
            sel_q   <= '0;
            rr_q    <= '0;
            null_q  <= 1'b0;
            idle_q  <= '0;
            dat_q   <= 8'h00;
            vld_q   <= 1'b0;
            psync_q <= 1'b0;
            give_q  <= '0;
            live_q  <= 1'b0;
            for (int s = 0; s < N_SRC; s++) begin
                cont_q[s] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            null_q  <= null_d;
            idle_q  <= idle_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            psync_q <= psync_d;
            give_q  <= give_d;
            live_q  <= live_d;
            for (int s = 0; s < N_SRC; s++) begin
                cont_q[s] <= cont_d[s];
            end
        end
    end

    assign DCLK_OUT               = SYS_CLK;
    assign bus.DATA_OUT           = dat_q;
    assign bus.D_VALID_OUT        = vld_q;
    assign bus.P_SYNC_OUT         = psync_q;
    assign bus.GIVE_ME_ONE_PACKET = give_q | give_early;
endmodule

// File: tb/tb_ts_packet_mux.sv
// Bench for ts_packet_mux: packet-level queue model checked every cycle, plus literal header/timing expectations.
module tb_ts_packet_mux;
    localparam int N_SRC       = 4;
    localparam int PKT_LEN     = 188;
    localparam int RD_LAT      = 2;
    localparam int NULL_INSERT = 1;
    localparam int NULL_GAP    = 16;
    localparam int PKT_CYC     = PKT_LEN + 5;

    typedef struct {
        logic [7:0] d;
        logic       ps;
    } ob_t;

    logic SYS_CLK = 1'b0;
    logic RST     = 1'b0;
    logic DCLK_OUT;

    ts_packet_mux_if #(.N_SRC(N_SRC)) bus_if ();

    ts_packet_mux #(
        .N_SRC(N_SRC), .PKT_LEN(PKT_LEN), .RD_LAT(RD_LAT),
        .NULL_INSERT(NULL_INSERT), .NULL_GAP(NULL_GAP)
    ) dut (
        .SYS_CLK (SYS_CLK),
        .RST     (RST),
        .DCLK_OUT(DCLK_OUT),
        .bus     (bus_if)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state
    ob_t        exp_q[$];
    int         m_rr, m_idle, give_cyc, give_src;
    logic [7:0] m_cont [N_SRC];

    // observation log
    bit          in_pkt;
    int          pidx, gap, len_last, psync_last, give_rel_last;
    logic [63:0] first8;
    logic [63:0] first8_log[$];
    int          gap_log[$];
    int          give_cnt [N_SRC];

    function automatic logic [7:0] src_byte(int i, int m);
        return 8'(m * 3 + i * 41 + 5);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(int g);
        logic [7:0] nh [8];
        ob_t e;
        nh = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h47, 8'h1F, 8'hFF, 8'h10};
        for (int k = 0; k < PKT_LEN + 4; k++) begin
            e.ps = (k == 4);
            if (g < 0)       e.d = (k < 8) ? nh[k] : 8'hFF;
            else if (k == 0) e.d = 8'(g);
            else if (k == 1) e.d = 8'(g + 2);
            else if (k == 2) e.d = m_cont[g];
            else if (k == 3) e.d = 8'h00;
            else             e.d = src_byte(g, cyc + k);  // byte k-4 sampled at end of cycle k-1
            exp_q.push_back(e);
        end
        if (g >= 0) m_cont[g] = m_cont[g] + 8'd1;
    endtask

    task automatic model_step();
        logic [N_SRC-1:0] eg;
        ob_t e;
        int g;
        if (!RST) begin
            exp_q.delete();
            m_rr = 0; m_idle = 0; give_cyc = -100; give_src = 0;
            for (int i = 0; i < N_SRC; i++) m_cont[i] = 8'h00;
            chk("rst_vld", bus_if.D_VALID_OUT, 0);
            chk("rst_dat", bus_if.DATA_OUT, 0);
            chk("rst_psync", bus_if.P_SYNC_OUT, 0);
            chk("rst_give", bus_if.GIVE_ME_ONE_PACKET, 0);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("arb_vld", bus_if.D_VALID_OUT, 0);
            chk("arb_dat", bus_if.DATA_OUT, 0);
            chk("arb_psync", bus_if.P_SYNC_OUT, 0);
            g = -1;
            for (int j = 0; j < N_SRC; j++) begin
                int s;
                s = (m_rr + j) % N_SRC;
                if (g < 0 && bus_if.GOT_FULL_PACKET[s] && bus_if.SRC_ENABLE[s]) g = s;
            end
            if (g >= 0) begin
                push_pkt(g);
                m_rr = (g + 1) % N_SRC;
                m_idle = 0;
                give_cyc = cyc + 4 - RD_LAT;
                give_src = g;
            end else if (NULL_INSERT != 0) begin
                m_idle++;
                if (m_idle == NULL_GAP) begin
                    push_pkt(-1);
                    m_idle = 0;
                end
            end
        end else begin
            e = exp_q.pop_front();
            chk("pkt_vld", bus_if.D_VALID_OUT, 1);
            chk("pkt_dat", bus_if.DATA_OUT, e.d);
            chk("pkt_psync", bus_if.P_SYNC_OUT, e.ps);
        end
        eg = '0;
        if (cyc == give_cyc) eg[give_src] = 1'b1;
        chk("give", bus_if.GIVE_ME_ONE_PACKET, eg);
    endtask

    task automatic capture_step();
        if (!RST) begin
            in_pkt = 0; gap = 0;
            return;
        end
        if (bus_if.D_VALID_OUT) begin
            if (!in_pkt) begin
                in_pkt = 1; pidx = 0; first8 = '0;
                gap_log.push_back(gap);
            end else begin
                pidx++;
            end
            if (pidx < 8) first8 = {first8[55:0], bus_if.DATA_OUT};
            if (pidx == 7) first8_log.push_back(first8);
            if (bus_if.P_SYNC_OUT) psync_last = pidx;
        end else begin
            if (in_pkt) begin
                len_last = pidx + 1; in_pkt = 0; gap = 0;
            end
            gap++;
        end
        if (bus_if.GIVE_ME_ONE_PACKET != '0) begin
            give_rel_last = in_pkt ? pidx : -1;
            for (int i = 0; i < N_SRC; i++)
                if (bus_if.GIVE_ME_ONE_PACKET[i]) give_cnt[i]++;
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < N_SRC; i++) bus_if.DATA_IN_BUS[8*i +: 8] = src_byte(i, cyc);
    endtask

    // Checks at the falling edge, then returns just after the next rising edge for input changes.
    task automatic tick();
        @(negedge SYS_CLK);
        model_step();
        capture_step();
        @(posedge SYS_CLK);
        #1;
        cyc++;
        drive_bus();
    endtask

    task automatic timeout_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=0 required=1", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench stopped on timeout");
    endtask

    task automatic wait_hdrs(int n, int budget, string name);
        int t = 0;
        while (first8_log.size() < n && t < budget) begin tick(); t++; end
        if (first8_log.size() < n) timeout_fail(name);
    endtask

    task automatic wait_end(int budget, string name);
        int t = 0;
        while (in_pkt && t < budget) begin tick(); t++; end
        if (in_pkt) timeout_fail(name);
    endtask

    task automatic wait_pidx(int target, int budget, string name);
        int t = 0;
        while (!(in_pkt && pidx == target) && t < budget) begin tick(); t++; end
        if (!(in_pkt && pidx == target)) timeout_fail(name);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
    endtask

    initial begin
        int b, gl, g2;
        logic [63:0] w;
        for (int i = 0; i < N_SRC; i++) give_cnt[i] = 0;
        bus_if.GOT_FULL_PACKET = '0;
        bus_if.SRC_ENABLE      = '1;
        drive_bus();
        repeat (3) tick();
        RST = 1'b1;

        // Nothing ready: null packet after NULL_GAP idle cycles.
        b = first8_log.size(); gl = gap_log.size();
        wait_hdrs(b + 1, 60, "null_start");
        w = first8_log[b];
        chk("null_first8", w, 64'hFFFF_0000_471F_FF10);
        chk("null_gap", gap_log[gl], NULL_GAP);
        chk("null_no_give", give_cnt[0] + give_cnt[1] + give_cnt[2] + give_cnt[3], 0);
        bus_if.GOT_FULL_PACKET = 4'b0001;
        wait_end(PKT_CYC, "null_end");
        chk("null_len", len_last, PKT_LEN + 4);

        // Only source 0 ready.
        wait_hdrs(b + 2, 10, "src0_start");
        bus_if.GOT_FULL_PACKET = 4'b0000;
        w = first8_log[b + 1];
        chk("src0_hdr", w[63:32], 32'h0002_0000);
        chk("src0_gap", gap_log[gl + 1], 1);
        chk("src0_give_cycle", give_rel_last, 3 - RD_LAT);
        wait_end(PKT_CYC, "src0_end");
        chk("src0_len", len_last, PKT_LEN + 4);
        chk("src0_psync_idx", psync_last, 4);
        chk("src0_give_cnt", give_cnt[0], 1);

        // All four ready from a clean reset.
        bus_if.GOT_FULL_PACKET = 4'b1111;
        do_reset();
        b = first8_log.size(); gl = gap_log.size();
        wait_hdrs(b + 5, 5 * PKT_CYC + 20, "rr_all");
        for (int k = 0; k < 5; k++) begin
            w = first8_log[b + k];
            chk($sformatf("rr_src%0d", k), w[63:56], (k == 4) ? 0 : k);
            chk($sformatf("rr_b1_%0d", k), w[55:48], ((k == 4) ? 0 : k) + 2);
            chk($sformatf("rr_cont%0d", k), w[47:40], (k == 4) ? 1 : 0);
            chk($sformatf("rr_gap%0d", k), gap_log[gl + k], 1);
        end

        // Source 2 disabled.
        bus_if.SRC_ENABLE = 4'b1011;
        do_reset();
        b = first8_log.size(); g2 = give_cnt[2];
        wait_hdrs(b + 4, 4 * PKT_CYC + 20, "rr_en");
        for (int k = 0; k < 4; k++) begin
            w = first8_log[b + k];
            chk($sformatf("en_src%0d", k), w[63:56], (k == 2) ? 3 : ((k == 3) ? 0 : k));
        end
        chk("en_src2_no_give", give_cnt[2], g2);

        // Reset in the middle of the payload, then source 1.
        bus_if.SRC_ENABLE = 4'b1111;
        bus_if.GOT_FULL_PACKET = 4'b0001;
        do_reset();
        wait_pidx(103, 2 * PKT_CYC, "mid_pkt");
        chk("pre_rst_vld", bus_if.D_VALID_OUT, 1);
        RST = 1'b0;
        #1;
        chk("rst_now_vld", bus_if.D_VALID_OUT, 0);
        chk("rst_now_dat", bus_if.DATA_OUT, 0);
        chk("rst_now_psync", bus_if.P_SYNC_OUT, 0);
        chk("rst_now_give", bus_if.GIVE_ME_ONE_PACKET, 0);
        bus_if.GOT_FULL_PACKET = 4'b0010;
        tick();
        tick();
        RST = 1'b1;
        b = first8_log.size(); gl = gap_log.size();
        wait_hdrs(b + 1, 20, "after_rst");
        w = first8_log[b];
        chk("after_rst_hdr", w[63:32], 32'h0103_0000);
        chk("after_rst_gap", gap_log[gl], 1);

        // Continuity counter wrap over 257 packets of source 1.
        do_reset();
        b = first8_log.size();
        wait_hdrs(b + 257, 257 * PKT_CYC + 20, "wrap");
        for (int k = 0; k < 257; k++) begin
            w = first8_log[b + k];
            chk($sformatf("wrap_cont%0d", k), w[47:40], k & 8'hFF);
        end
        w = first8_log[b + 255];
        chk("wrap_ff", w[47:40], 8'hFF);
        w = first8_log[b + 256];
        chk("wrap_00", w[47:40], 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ts_packet_mux.md
# ts_packet_mux

Parametrised round-robin multiplexer that merges N_SRC buffered TS sources into one byte-wide output stream. Each forwarded packet gets a 4-byte pseudo-header: PLP ID, stream source, per-source continuity counter, reserved. Null-packet stuffing keeps the output alive when no source is ready. It sits between the per-channel packet buffers, which raise GOT_FULL_PACKET, and the downstream modulator/serialiser, which consumes DCLK_OUT/D_VALID_OUT/P_SYNC_OUT.

## Interface
- N_SRC, 4: number of sources, 1..16.
- PKT_LEN, 188: TS payload bytes per packet.
- RD_LAT, 2: cycles from a GIVE_ME_ONE_PACKET pulse to payload byte 0 on DATA_IN_BUS; legal range 1..4.
- NULL_INSERT, 1: 1 enables null-packet stuffing.
- NULL_GAP, 16: consecutive idle cycles without a grant before a null packet is emitted; minimum 1.
- SYS_CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous active-low reset.
- GOT_FULL_PACKET  in  N_SRC  bit i high means source i holds at least one complete packet.
- SRC_ENABLE  in  N_SRC  bit i low means source i is never granted.
- DATA_IN_BUS  in  8*N_SRC  source i byte on bits [8i+7:8i].
- GIVE_ME_ONE_PACKET  out  N_SRC  one-cycle read-request pulse per granted source.
- DATA_OUT  out  8  output byte, registered.
- DCLK_OUT  out  1  equals SYS_CLK (direct assign).
- D_VALID_OUT  out  1  high while a header or payload byte is on DATA_OUT.
- P_SYNC_OUT  out  1  high on payload byte 0 only.

## Operation
- States: ARB, HEADER (4 cycles), PAYLOAD (PKT_LEN cycles). After the last payload byte the FSM returns to ARB.
- ARB:
  - Samples GOT_FULL_PACKET & SRC_ENABLE in a single cycle.
  - Grants the first ready source at or after the round-robin pointer, with wrap-around.
  - On a grant the pointer becomes the grant index + 1, mod N_SRC.
  - With no grant the FSM stays in ARB and DATA_OUT = 0.
- Header bytes for source i:
  - byte0 = i.
  - byte1 = i + 2 (8-bit).
  - byte2 = cont[i].
  - byte3 = 0x00.
- cont[i] is an 8-bit counter. It increments when packet i finishes and wraps 0xFF→0x00.
- Payload: DATA_OUT takes DATA_IN_BUS[i] registered. Exactly PKT_LEN bytes are forwarded.
- Null stuffing (NULL_INSERT = 1):
  - Idle counter counts consecutive ARB cycles without a grant and clears on any grant.
  - When it reaches NULL_GAP, the block emits a null packet instead of staying in ARB, and the counter clears.
  - Null header is FF FF 00 00.
  - Null payload is 47 1F FF 10, then 0xFF fill up to PKT_LEN.
  - No GIVE pulse is issued; no cont[] changes; the round-robin pointer is unchanged.
- When NULL_INSERT = 0 the idle counter is inert.
- SRC_ENABLE and GOT_FULL_PACKET are sampled only in ARB. Changes during a packet never abort it.
- Reset (asynchronous, any time, including mid-packet) clears:
  - FSM to ARB, pointer to 0, all cont[] to 0, idle counter to 0.
  - DATA_OUT 0, D_VALID_OUT 0, P_SYNC_OUT 0, GIVE_ME_ONE_PACKET 0.
- A source left mid-read by reset is not this block's concern.
- Byte counter width is clog2(PKT_LEN+4).

## Timing
- Cycle 0 = the first cycle D_VALID_OUT is high (header byte0 on DATA_OUT). The ARB cycle that granted is cycle −1.
- Header bytes appear in cycles 0..3. Payload byte k appears in cycle 4+k.
- D_VALID_OUT is high in cycles 0..PKT_LEN+3 and falls in cycle PKT_LEN+4.
- P_SYNC_OUT is high exactly in cycle 4.
- GIVE_ME_ONE_PACKET[i] is high for exactly one cycle, cycle 3−RD_LAT (cycle −1 when RD_LAT = 4).
- DATA_IN_BUS[i] byte k is sampled at the end of cycle 3+k.
- Minimum inter-packet gap is 1 ARB cycle with D_VALID_OUT low. Back-to-back packets repeat every PKT_LEN+5 cycles.
- Null packet: same cycle layout as a source packet; it starts in the cycle after the NULL_GAP-th idle ARB cycle.

## Test plan
- Only source 0 ready, defaults:
  - Pulse GIVE[0] in cycle 1.
  - Output 00 02 00 00 then 188 bytes; P_SYNC in cycle 4; D_VALID high for 192 cycles.
- All four sources always ready:
  - Grant order 0,1,2,3,0,…
  - byte2 sequence 00,00,00,00,01; gaps exactly 1 cycle.
- SRC_ENABLE = 4'b1011, all ready → order 0,1,3,0; source 2 is never pulsed.
- No source ready, NULL_INSERT = 1 → after 16 idle cycles the output is FF FF 00 00 47 1F FF 10 FF…; no GIVE pulse; cont[] unchanged.
- Reset asserted at payload byte 100 → all outputs 0 immediately. After release, source 1 ready → header 01 03 00 00.
- Source 1 forwards 257 packets → byte2 runs 00…FF, then 00.
